loop_iter_gen: RTL and testbench
================================

# loop_iter_gen

Parametrised multi-level loop iteration generator for the CGRA dataflow fabric. It replaces the hand-built counter chain of const, ALU add, reg_unit and compare feeding a branch IO. It produces nested index tuples (start/bound/step per level) under a valid/ready handshake, with a continue flag and a completion pulse. It sits between the array configuration/control port and the address-generation ALUs and Mem units, sharing the fabric's global enable.

## Interface
- `WIDTH`, 32: index/bound/step width in bits.
- `LEVELS`, 2: nesting depth. Level 0 is innermost. Legal range 1..4.
- `UserCLK` in 1: fabric clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: global enable. When low, all state and outputs freeze.
- `start` in 1: one-cycle request that latches the config and begins a run. Honoured only in IDLE with `en`=1.
- `cfg_start` in LEVELS*WIDTH: per-level start value. Slice k is level k.
- `cfg_bound` in LEVELS*WIDTH: per-level bound.
- `cfg_step` in LEVELS*WIDTH: per-level step, two's complement.
- `cfg_cmp` in 2: continue condition for all levels. 0 = signed `idx<bound`, 1 = signed `idx<=bound`, 2 = `idx!=bound`, 3 = unsigned `idx<bound`.
- `busy` out 1: high from the accepted `start` until the cycle `done` pulses, inclusive.
- `idx_out` out LEVELS*WIDTH: current index tuple.
- `idx_valid` out 1: `idx_out` is a valid beat.
- `idx_ready` in 1: consumer accepts the beat.
- `last` out LEVELS: bit k is high when level k wraps or exits after this beat.
- `cont` out 1: high on a valid beat that is not the final beat. This is the branch-predicate equivalent.
- `done` out 1: one-cycle pulse at the end of the run.

## Operation
- States:
  - IDLE: `start` → CHECK.
  - CHECK: evaluates every level's start value against its condition. If any level fails, go to DONE (zero-trip run). Otherwise go to RUN, load idx = start, and raise `idx_valid`.
  - RUN: holds until a beat is accepted.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- A beat is accepted when `idx_valid & idx_ready & en`.
- On each accepted beat, level 0 computes idx+step in WIDTH+1 bits.
  - Arithmetic overflow, or the condition being false on the result, counts as exit: the level reloads its start value and carries into level 1. Carry chains outward the same way.
  - Carry out of level LEVELS-1 ends the run: go to DONE and drop `idx_valid`.
- `last[k]` = level k and all inner levels exit on the next increment. It is computed combinationally from the precomputed next values.
- `cont` = `idx_valid & ~last[LEVELS-1]`.
- `cfg_*` inputs are sampled only at the accepted `start`. Changing them during a run has no effect.
- `start` while busy is ignored. No queueing.
- Mode 2 with a step that never lands on bound produces an endless run (modulo 2^WIDTH wrap is ignored in mode 2). This is legal and the caller's responsibility.

## Timing
- Reset values: state IDLE, `idx_out`=0, `idx_valid`=0, `last`=0, `cont`=0, `busy`=0, `done`=0.
- Reset mid-run aborts immediately (asynchronous). No `done` pulse.
- Latency: `start` at cycle t gives `idx_valid` at t+2, and `busy` at t+1.
- Throughput is one beat per cycle under continuous `idx_ready`.
- `idx_out` is registered and stays stable while `idx_valid & ~idx_ready`.
- Final beat accepted at cycle t gives `done` at t+1 and `busy` low at t+2.
- Zero-trip run: `start` at t gives `done` at t+2, with no valid beats.
- `en` low stalls every register, including the `done` pulse. That pulse is held and emitted when `en` returns.

## Configuration
- `LOOP_ITER_PERF_EN` defined: adds output `perf_beats` [WIDTH].
  - Counts accepted beats and saturates at all-ones.
  - Cleared on the accepted `start`. Reset value 0.
- Without the macro, the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Package `loop_iter_pkg`:
  - `cmp_mode_t` enum (CMP_SLT, CMP_SLE, CMP_NE, CMP_ULT).
  - `state_t` enum (IDLE, CHECK, RUN, DONE).
  - Function `cond_ok(mode, a, b)`.
- Sub-module `loop_iter_level`: one level's index register, next-value adder with overflow detection, condition check, and reload/carry logic. It is instantiated LEVELS times in a generate loop. The FSM and handshake live in the top level.

## Test plan
- LEVELS=1, start=0, bound=20, step=1, mode 0, ready=1 → 20 beats with idx 0..19. `last[0]` and `cont`=0 only on idx 19. `done` one cycle after the idx-19 beat.
- Zero trip: start=5, bound=5, mode 0 → no `idx_valid`. `done` at start+2. `busy` high for cycles t+1..t+2.
- LEVELS=2: outer 0/3/1, inner 0/5/2, mode 0 → 9 beats (0,0),(0,2),(0,4),(1,0)…(2,4). `last[0]` on every inner 4. `last[1]` only on (2,4).
- Backpressure: `idx_ready` pattern 1,0,0,1 and `en` low for 3 cycles mid-run → `idx_out` stable during stalls, no beats lost or duplicated, and `perf_beats` (with macro) equals the beat count.
- Overflow: mode 3, start=0xFFFFFFF0, bound=0xFFFFFFFF, step=8 → exactly 2 beats (0xFFFFFFF0, 0xFFFFFFF8), then `done`.
- `rst_n` asserted mid-run, and `start` pulsed during RUN → on reset, all outputs are 0 immediately. The mid-run `start` is ignored and the run completes unaltered.

Source files
------------

// File: rtl/loop_iter_pkg.sv
// Shared types and the comparison helper for the loop iteration generator.
// Operands reach cond_ok already widened to CMP_W bits by the caller.
package loop_iter_pkg;

  localparam int CMP_W = 64;

  typedef enum logic [1:0] {
    CMP_SLT = 2'd0,
    CMP_SLE = 2'd1,
    CMP_NE  = 2'd2,
    CMP_ULT = 2'd3
  } cmp_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Signed modes expect sign-extended operands, CMP_ULT zero-extended ones.
  function automatic logic cond_ok(cmp_mode_t mode, logic [CMP_W-1:0] a, logic [CMP_W-1:0] b);
    logic r;
    r = 1'b0;
    case (mode)
      CMP_SLT: r = $signed(a) <  $signed(b);
      CMP_SLE: r = $signed(a) <= $signed(b);
      CMP_NE:  r = (a != b);
      default: r = (a < b);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/loop_iter_level.sv
// One nesting level: latched config, index register, next-value adder with
// overflow detection, and the continue-condition checks for start and next.
module loop_iter_level
  import loop_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             UserCLK,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_latch,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_bound,
  input  logic [WIDTH-1:0] cfg_step,
  input  cmp_mode_t        mode,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] idx,
  output logic             start_ok,
  output logic             exit_next
);

  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] bound_r;
  logic [WIDTH-1:0] step_r;
  logic [WIDTH:0]   sum;
  logic             ovf;

  function automatic logic [CMP_W-1:0] widen(logic [WIDTH-1:0] v, cmp_mode_t m);
    logic [CMP_W-1:0] r;
    if (m == CMP_ULT) r = CMP_W'(v);
    else              r = CMP_W'($signed(v));
    return r;
  endfunction

  assign sum = {1'b0, idx} + {1'b0, step_r};

  // Mode NE ignores wrap; unsigned mode treats a negative step as a borrow.
  always_comb begin
    ovf = 1'b0;
    case (mode)
      CMP_NE:  ovf = 1'b0;
      CMP_ULT: ovf = sum[WIDTH] ^ step_r[WIDTH-1];
      default: ovf = (idx[WIDTH-1] == step_r[WIDTH-1]) && (sum[WIDTH-1] != idx[WIDTH-1]);
    endcase
  end

  assign start_ok  = cond_ok(mode, widen(start_r, mode), widen(bound_r, mode));
  assign exit_next = ovf | ~cond_ok(mode, widen(sum[WIDTH-1:0], mode), widen(bound_r, mode));

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= '0;
      bound_r <= '0;
      step_r  <= '0;
      idx     <= '0;
    end else if (en) begin
      if (cfg_latch) begin
        start_r <= cfg_start;
        bound_r <= cfg_bound;
        step_r  <= cfg_step;
      end
      if (load) begin
        idx <= start_r;
      end else if (inc) begin
        idx <= exit_next ? start_r : sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/loop_iter_gen.sv
// Multi-level loop iteration generator: FSM, handshake and level chaining.
// Optional beat counter output perf_beats is enabled by LOOP_ITER_PERF_EN.
module loop_iter_gen
  import loop_iter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LEVELS = 2
) (
  input  logic                    UserCLK,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic [LEVELS*WIDTH-1:0] cfg_start,
  input  logic [LEVELS*WIDTH-1:0] cfg_bound,
  input  logic [LEVELS*WIDTH-1:0] cfg_step,
  input  logic [1:0]              cfg_cmp,
  output logic                    busy,
  output logic [LEVELS*WIDTH-1:0] idx_out,
  output logic                    idx_valid,
  input  logic                    idx_ready,
  output logic [LEVELS-1:0]       last,
  output logic                    cont,
  output logic                    done
`ifdef LOOP_ITER_PERF_EN
  ,
  output logic [WIDTH-1:0]        perf_beats
`endif
);

  state_t            state;
  cmp_mode_t         mode_r;
  logic              start_acc;
  logic              beat;
  logic              load;
  logic              all_ok;
  logic [LEVELS-1:0] start_ok;
  logic [LEVELS-1:0] exit_next;
  logic [LEVELS-1:0] last_raw;
  logic [LEVELS-1:0] inc;

  assign start_acc = en & start & (state == IDLE);
  assign beat      = en & idx_valid & idx_ready;
  assign load      = en & (state == CHECK);
  assign all_ok    = &start_ok;

  // A level advances only when every inner level wraps on this beat.
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    assign last_raw[k] = &exit_next[k:0];

    if (k == 0) begin : g_inner
      assign inc[k] = beat;
    end else begin : g_outer
      assign inc[k] = beat & last_raw[k-1];
    end

    loop_iter_level #(
      .WIDTH(WIDTH)
    ) u_level (
      .UserCLK  (UserCLK),
      .rst_n    (rst_n),
      .en       (en),
      .cfg_latch(start_acc),
      .cfg_start(cfg_start[k*WIDTH +: WIDTH]),
      .cfg_bound(cfg_bound[k*WIDTH +: WIDTH]),
      .cfg_step (cfg_step[k*WIDTH +: WIDTH]),
      .mode     (mode_r),
      .load     (load),
      .inc      (inc[k]),
      .idx      (idx_out[k*WIDTH +: WIDTH]),
      .start_ok (start_ok[k]),
      .exit_next(exit_next[k])
    );
  end

  assign last = idx_valid ? last_raw : '0;
  assign cont = idx_valid & ~last_raw[LEVELS-1];

  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_r    <= CMP_SLT;
      busy      <= 1'b0;
      idx_valid <= 1'b0;
      done      <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_r <= cmp_mode_t'(cfg_cmp);
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (all_ok) begin
            idx_valid <= 1'b1;
            state     <= RUN;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        RUN: begin
          if (beat && last_raw[LEVELS-1]) begin
            idx_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOOP_ITER_PERF_EN
  always_ff @(posedge UserCLK or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats <= '0;
    end else if (start_acc) begin
      perf_beats <= '0;
    end else if (beat && (perf_beats != '1)) begin
      perf_beats <= perf_beats + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_loop_iter_gen.sv
// Self-checking bench for loop_iter_gen: directed and random runs against an
// odometer-style reference model built from the iteration rules.
module tb_loop_iter_gen;

  localparam int WIDTH  = 32;
  localparam int LEVELS = 2;

  logic                    UserCLK = 1'b0;
  logic                    rst_n;
  logic                    en;
  logic                    start;
  logic [LEVELS*WIDTH-1:0] cfg_start;
  logic [LEVELS*WIDTH-1:0] cfg_bound;
  logic [LEVELS*WIDTH-1:0] cfg_step;
  logic [1:0]              cfg_cmp;
  logic                    busy;
  logic [LEVELS*WIDTH-1:0] idx_out;
  logic                    idx_valid;
  logic                    idx_ready;
  logic [LEVELS-1:0]       last;
  logic                    cont;
  logic                    done;
`ifdef LOOP_ITER_PERF_EN
  logic [WIDTH-1:0]        perf_beats;
`endif

  loop_iter_gen #(
    .WIDTH (WIDTH),
    .LEVELS(LEVELS)
  ) dut (
    .UserCLK  (UserCLK),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .cfg_start(cfg_start),
    .cfg_bound(cfg_bound),
    .cfg_step (cfg_step),
    .cfg_cmp  (cfg_cmp),
    .busy     (busy),
    .idx_out  (idx_out),
    .idx_valid(idx_valid),
    .idx_ready(idx_ready),
    .last     (last),
    .cont     (cont),
    .done     (done)
`ifdef LOOP_ITER_PERF_EN
    ,
    .perf_beats(perf_beats)
`endif
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic [LEVELS*WIDTH-1:0] idx;
    logic [LEVELS-1:0]       lst;
  } beat_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       exp_q[$];
  logic [31:0] c_start [LEVELS];
  logic [31:0] c_bound [LEVELS];
  logic [31:0] c_step  [LEVELS];

  localparam longint S_MAX = 64'sd2147483647;
  localparam longint S_MIN = -64'sd2147483648;
  localparam longint U_MAX = 64'sd4294967295;

  task automatic checkOutput(string tag, logic [63:0] observed, logic [63:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit m_cond(int mode, logic [31:0] a, logic [31:0] b);
    case (mode)
      0:       return $signed(a) <  $signed(b);
      1:       return $signed(a) <= $signed(b);
      2:       return a != b;
      default: return a < b;
    endcase
  endfunction

  // Exact-integer step: any result outside the mode's number range is an exit.
  function automatic bit m_exit(int mode, logic [31:0] idx, logic [31:0] step,
                                logic [31:0] bound, output logic [31:0] nxt);
    longint r;
    bit     ovf;
    if (mode == 2) begin
      nxt = idx + step;
      return nxt == bound;
    end
    if (mode == 3) begin
      r   = longint'({32'b0, idx}) + longint'($signed(step));
      ovf = (r < 0) || (r > U_MAX);
    end else begin
      r   = longint'($signed(idx)) + longint'($signed(step));
      ovf = (r < S_MIN) || (r > S_MAX);
    end
    nxt = r[31:0];
    return ovf || !m_cond(mode, nxt, bound);
  endfunction

  task automatic build_model(int mode);
    logic [31:0] cur [LEVELS];
    logic [31:0] nx  [LEVELS];
    bit          ex  [LEVELS];
    beat_t       b;
    bit          acc;
    int          k;
    exp_q.delete();
    for (int j = 0; j < LEVELS; j++) begin
      cur[j] = c_start[j];
      if (!m_cond(mode, c_start[j], c_bound[j])) return;
    end
    for (int guard = 0; guard < 400; guard++) begin
      acc = 1'b1;
      for (int j = 0; j < LEVELS; j++) begin
        b.idx[j*WIDTH +: WIDTH] = cur[j];
        ex[j]    = m_exit(mode, cur[j], c_step[j], c_bound[j], nx[j]);
        acc      = acc & ex[j];
        b.lst[j] = acc;
      end
      exp_q.push_back(b);
      k = 0;
      while (k < LEVELS && ex[k]) begin
        cur[k] = c_start[k];
        k++;
      end
      if (k == LEVELS) return;
      cur[k] = nx[k];
    end
  endtask

  task automatic set_level(int k, logic [31:0] s, logic [31:0] b, logic [31:0] st);
    c_start[k] = s;
    c_bound[k] = b;
    c_step[k]  = st;
  endtask

  task automatic applyStimulus(int mode);
    for (int k = 0; k < LEVELS; k++) begin
      cfg_start[k*WIDTH +: WIDTH] = c_start[k];
      cfg_bound[k*WIDTH +: WIDTH] = c_bound[k];
      cfg_step[k*WIDTH +: WIDTH]  = c_step[k];
    end
    cfg_cmp   = 2'(mode);
    start     = 1'b1;
    en        = 1'b1;
    idx_ready = 1'b0;
  endtask

  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_case(string name, int mode, int rdy_mode, int gap_at, bit poke, bit done_hold);
    int cyc = 0, beats = 0, gap = 0, ph = 0, n_exp;
    bit gap_used = 1'b0;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    build_model(mode);
    n_exp = exp_q.size();
    @(negedge UserCLK);
    applyStimulus(mode);
    @(negedge UserCLK);
    start = 1'b0;
    #1;
    checkOutput({name, ":busy_t1"}, busy, 1);
    checkOutput({name, ":valid_t1"}, idx_valid, 0);
    if (n_exp == 0) begin
      @(negedge UserCLK); #1;
      checkOutput({name, ":zt_done"}, done, 1);
      checkOutput({name, ":zt_busy"}, busy, 1);
      checkOutput({name, ":zt_valid"}, idx_valid, 0);
      @(negedge UserCLK); #1;
      checkOutput({name, ":zt_done_end"}, done, 0);
      checkOutput({name, ":zt_busy_end"}, busy, 0);
`ifdef LOOP_ITER_PERF_EN
      checkOutput({name, ":zt_perf"}, perf_beats, 0);
`endif
      return;
    end
    while (exp_q.size() > 0 && cyc < 2000) begin
      @(negedge UserCLK);
      case (rdy_mode)
        0:       idx_ready = 1'b1;
        1:       begin idx_ready = pat[ph % 4]; ph++; end
        default: idx_ready = ($urandom_range(0, 99) < 60);
      endcase
      if (gap_at == beats && !gap_used) begin
        gap      = 3;
        gap_used = 1'b1;
      end
      en = (gap == 0);
      if (gap > 0) gap--;
      start     = poke && (cyc == 3);
      cfg_start = {$urandom, $urandom};
      cfg_bound = {$urandom, $urandom};
      cfg_step  = {$urandom, $urandom};
      cfg_cmp   = 2'($urandom);
      #1;
      checkOutput({name, ":valid"}, idx_valid, 1);
      checkOutput({name, ":idx"}, idx_out, exp_q[0].idx);
      checkOutput({name, ":last"}, last, exp_q[0].lst);
      checkOutput({name, ":cont"}, cont, !exp_q[0].lst[LEVELS-1]);
      checkOutput({name, ":busy"}, busy, 1);
      checkOutput({name, ":done_early"}, done, 0);
      if (idx_ready && en) begin
        void'(exp_q.pop_front());
        beats++;
      end
      cyc++;
    end
    checkOutput({name, ":beats_left"}, exp_q.size(), 0);
    @(negedge UserCLK);
    start     = 1'b0;
    idx_ready = 1'($urandom);
    en        = !done_hold;
    #1;
    checkOutput({name, ":done"}, done, 1);
    checkOutput({name, ":busy_done"}, busy, 1);
    checkOutput({name, ":valid_done"}, idx_valid, 0);
    checkOutput({name, ":cont_done"}, cont, 0);
    checkOutput({name, ":last_done"}, last, 0);
`ifdef LOOP_ITER_PERF_EN
    checkOutput({name, ":perf"}, perf_beats, n_exp);
`endif
    if (done_hold) begin
      @(negedge UserCLK); en = 1'b0; #1;
      checkOutput({name, ":done_hold"}, done, 1);
      @(negedge UserCLK); en = 1'b1; #1;
      checkOutput({name, ":done_release"}, done, 1);
      checkOutput({name, ":busy_release"}, busy, 1);
    end
    @(negedge UserCLK); #1;
    checkOutput({name, ":done_end"}, done, 0);
    checkOutput({name, ":busy_end"}, busy, 0);
    @(negedge UserCLK); #1;
    checkOutput({name, ":idle"}, busy, 0);
  endtask

  initial begin
    int          m;
    logic [31:0] s, st, b;
    int          n;

    rst_n     = 1'b0;
    en        = 1'b1;
    start     = 1'b0;
    idx_ready = 1'b0;
    cfg_start = '0;
    cfg_bound = '0;
    cfg_step  = '0;
    cfg_cmp   = '0;
    repeat (2) @(negedge UserCLK);
    #1;
    checkOutput("rst_idx", idx_out, 0);
    checkOutput("rst_valid", idx_valid, 0);
    checkOutput("rst_last", last, 0);
    checkOutput("rst_cont", cont, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
`ifdef LOOP_ITER_PERF_EN
    checkOutput("rst_perf", perf_beats, 0);
`endif
    @(negedge UserCLK);
    rst_n = 1'b1;

    $display("[TB] single level count 0..19");
    set_level(0, 32'd0, 32'd20, 32'd1);
    set_level(1, 32'd0, 32'd1, 32'd1);
    run_case("single", 0, 0, -1, 1'b0, 1'b0);

    $display("[TB] zero-trip runs");
    set_level(0, 32'd5, 32'd5, 32'd1);
    run_case("zero_inner", 0, 0, -1, 1'b0, 1'b0);
    set_level(0, 32'd0, 32'd3, 32'd1);
    set_level(1, 32'd4, 32'd2, 32'd1);
    run_case("zero_outer", 0, 0, -1, 1'b0, 1'b0);

    $display("[TB] nested and backpressure");
    set_level(0, 32'd0, 32'd5, 32'd2);
    set_level(1, 32'd0, 32'd3, 32'd1);
    run_case("nested", 0, 0, -1, 1'b0, 1'b0);
    run_case("backpressure", 0, 1, 3, 1'b1, 1'b1);

    $display("[TB] overflow and compare modes");
    set_level(0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd8);
    set_level(1, 32'd0, 32'd1, 32'd1);
    run_case("uovf", 3, 0, -1, 1'b0, 1'b0);
    set_level(0, 32'h7FFF_FFFC, 32'h7FFF_FFFF, 32'd2);
    run_case("sovf", 0, 0, -1, 1'b0, 1'b0);
    set_level(0, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 32'd1);
    set_level(1, 32'hFFFF_FFFE, 32'd0, 32'd1);
    run_case("sle", 1, 2, 2, 1'b0, 1'b0);
    set_level(0, 32'd0, 32'd12, 32'd3);
    set_level(1, 32'd10, 32'd4, 32'hFFFF_FFFD);
    run_case("ne", 2, 0, -1, 1'b0, 1'b0);
    set_level(0, 32'd5, 32'd10, 32'hFFFF_FFFE);
    set_level(1, 32'd0, 32'd2, 32'd1);
    run_case("uneg", 3, 2, 1, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-run");
    set_level(0, 32'd0, 32'd5, 32'd2);
    set_level(1, 32'd0, 32'd3, 32'd1);
    @(negedge UserCLK);
    applyStimulus(0);
    @(negedge UserCLK);
    start     = 1'b0;
    idx_ready = 1'b1;
    repeat (4) @(negedge UserCLK);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", idx_valid, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_cont", cont, 0);
    checkOutput("arst_last", last, 0);
    checkOutput("arst_idx", idx_out, 0);
    @(negedge UserCLK);
    rst_n = 1'b1;
    @(negedge UserCLK); #1;
    checkOutput("arst_no_done", done, 0);
    checkOutput("arst_idle", busy, 0);
    run_case("after_reset", 0, 2, 0, 1'b1, 1'b0);

    $display("[TB] random configurations");
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, 3);
      for (int k = 0; k < LEVELS; k++) begin
        s  = $urandom_range(0, 1000);
        st = $urandom_range(1, 3);
        n  = $urandom_range(0, 4);
        b  = s + st * n;
        if (m == 0 || m == 3) b = b + $urandom_range(0, 1);
        set_level(k, s, b, st);
      end
      run_case($sformatf("rand%0d", r), m, 2, $urandom_range(0, 4), 1'b1, (r % 2) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
